// File: rtl/elastic_pipe_reg.sv
// ---------------------------------------------------------------------------
// elastic_pipe_reg
//
// Multi-stage pipeline register with a valid bit per stage and a valid/ready
// handshake on both sides. It replaces a fixed enable-register chain between
// processor pipeline stages. While the consumer stalls, entries keep sliding
// forward into empty stages, so bubbles are squeezed out and up to DEPTH
// entries are held without loss. A synchronous flush drops every in-flight
// entry in one edge.
//
// Parameters
//   WIDTH      payload bits per stage (>= 1)
//   DEPTH      number of register stages (>= 1)
//   RESET_VAL  payload value loaded into every stage while reset is asserted
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset (0 = reset asserted)
//   flush      synchronous squash of all stages
//   in_valid   upstream presents in_data
//   in_ready   block accepts in_data this cycle
//   in_data    upstream payload
//   out_valid  last stage holds a valid entry
//   out_ready  downstream accepts out_data this cycle
//   out_data   payload of the last stage
//   count      number of valid stages
// ---------------------------------------------------------------------------
module elastic_pipe_reg #(
    parameter int                 WIDTH     = 64,
    parameter int                 DEPTH     = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] stageValid_q;
    logic [DEPTH-1:0] stageValid_d;
    logic [WIDTH-1:0] stageData_q [DEPTH];
    logic [WIDTH-1:0] stageData_d [DEPTH];
    logic [DEPTH-1:0] stageRdy;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // A stage may load on the next edge if it is empty or if the stage ahead
    // of it is going to move. The chain starts at the output, where the
    // consumer's out_ready plays the role of "the stage ahead moves".
    always_comb begin
        logic chain;
        stageRdy = '0;
        chain    = out_ready | ~stageValid_q[DEPTH-1];
        stageRdy[DEPTH-1] = chain;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            chain       = ~stageValid_q[i] | chain;
            stageRdy[i] = chain;
        end
    end

    // Next-state for every stage. Flush only clears the valid bits; stale
    // payloads stay in place since nothing reads them without a valid bit.
    // A stage that is not ready keeps both its valid bit and its payload.
    // Payload registers only load when the incoming entry is valid, so an
    // empty stage keeps its old value and out_data stays stable when empty.
    always_comb begin
        stageValid_d = stageValid_q;
        stageData_d  = stageData_q;
        if (flush) begin
            stageValid_d = '0;
        end else begin
            if (stageRdy[0]) begin
                stageValid_d[0] = in_valid;
                if (in_valid) begin
                    stageData_d[0] = in_data;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (stageRdy[i]) begin
                    stageValid_d[i] = stageValid_q[i-1];
                    if (stageValid_q[i-1]) begin
                        stageData_d[i] = stageData_q[i-1];
                    end
                end
            end
        end
    end

    // Occupancy is the population count of the next valid vector, so the
    // registered count always agrees with the registered valid bits.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(stageValid_d[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stageValid_q <= '0;
            count_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stageData_q[i] <= RESET_VAL;
            end
        end else begin
            stageValid_q <= stageValid_d;
            stageData_q  <= stageData_d;
            count_q      <= count_d;
        end
    end

    // in_ready is forced low while reset is held and during a flush cycle,
    // so nothing is reported as accepted in either case.
    assign in_ready  = stageRdy[0] & ~flush & reset;
    assign out_valid = stageValid_q[DEPTH-1];
    assign out_data  = stageData_q[DEPTH-1];
    assign count     = count_q;

endmodule
